hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: one latency countdown per architectural register drives
// load-use stalls, ID/EX bubbles and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 3,
    parameter int CW      = 2,
    parameter int SC_W    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [REG_AW-1:0]      id_rs_i,
    input  logic [REG_AW-1:0]      id_rt_i,
    input  logic                   id_rs_used_i,
    input  logic                   id_rt_used_i,
    input  logic [REG_AW-1:0]      id_rd_i,
    input  logic                   id_wr_i,
    input  logic [CW-1:0]          id_lat_i,
    input  logic                   flush_i,
    input  logic                   freeze_i,
    output logic                   pc_write_o,
    output logic                   if_id_write_o,
    output logic                   bubble_o,
    output logic [2**REG_AW-1:0]   pending_o,
    output logic [SC_W-1:0]        stall_cnt_o
);
    localparam int NREG = 2**REG_AW;
    localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [SC_W-1:0] stall_cnt_q;
    logic [SC_W-1:0] stall_cnt_d;
    logic            hazard;
    logic            stall;
    logic            issue;
    logic            load_en;
    logic [CW-1:0]   lat_clamped;
    logic [CW-1:0]   dec_rd;
    logic [CW-1:0]   load_val;

    // Hazards look only at the prior counts, so an instruction never waits on itself.
    assign hazard = (id_rs_used_i && (cnt_q[id_rs_i] != '0)) ||
                    (id_rt_used_i && (cnt_q[id_rt_i] != '0));
    assign stall  = id_valid_i && !flush_i && !freeze_i && hazard;
    assign issue  = id_valid_i && !stall && !flush_i && !freeze_i;

    assign pc_write_o    = !stall && !freeze_i;
    assign if_id_write_o = !stall && !freeze_i;
    assign bubble_o      = (stall || flush_i) && !freeze_i;
    assign stall_cnt_o   = stall_cnt_q;

    assign load_en     = issue && id_wr_i && (id_rd_i != '0) && (id_lat_i != '0);
    assign lat_clamped = (id_lat_i > MAX_LAT_C) ? MAX_LAT_C : id_lat_i;
    assign dec_rd      = (cnt_q[id_rd_i] != '0) ? cnt_q[id_rd_i] - CW'(1) : '0;
    // A WAW rewrite keeps whichever result lands later.
    assign load_val    = (dec_rd > lat_clamped) ? dec_rd : lat_clamped;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r]     = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            pending_o[r] = (cnt_q[r] != '0);
        end
        if (load_en) begin
            cnt_d[id_rd_i] = load_val;
        end
        cnt_d[0] = '0;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end
    end

    // NOTE: the count array is a handful of flops that must clear asynchronously,
    // so every entry is reset explicitly instead of being left as an unreset RAM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            if (!freeze_i) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt_q[r] <= cnt_d[r];
                end
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a timestamp-based
// reference model: each register records the absolute tick its result is ready.
module tb_hazard_scoreboard;
    localparam int REG_AW  = 5;
    localparam int MAX_LAT = 3;
    localparam int CW      = 2;
    localparam int SC_W    = 5;
    localparam int NREG    = 2**REG_AW;
    localparam int SC_MAX  = 2**SC_W - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_rs_used_i;
    logic              id_rt_used_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_wr_i;
    logic [CW-1:0]     id_lat_i;
    logic              flush_i;
    logic              freeze_i;
    logic              pc_write_o;
    logic              if_id_write_o;
    logic              bubble_o;
    logic [NREG-1:0]   pending_o;
    logic [SC_W-1:0]   stall_cnt_o;

    int     checks   = 0;
    int     failures = 0;
    longint t_now    = 0;
    longint ready [NREG];
    int     stall_model = 0;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .MAX_LAT(MAX_LAT),
        .CW     (CW),
        .SC_W   (SC_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rs_used_i (id_rs_used_i),
        .id_rt_used_i (id_rt_used_i),
        .id_rd_i      (id_rd_i),
        .id_wr_i      (id_wr_i),
        .id_lat_i     (id_lat_i),
        .flush_i      (flush_i),
        .freeze_i     (freeze_i),
        .pc_write_o   (pc_write_o),
        .if_id_write_o(if_id_write_o),
        .bubble_o     (bubble_o),
        .pending_o    (pending_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pending(input int r);
        return (r != 0) && (ready[r] > t_now);
    endfunction

    function automatic bit m_stall();
        bit hz;
        hz = (id_rs_used_i && m_pending(int'(id_rs_i))) ||
             (id_rt_used_i && m_pending(int'(id_rt_i)));
        return id_valid_i && !flush_i && !freeze_i && hz;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready[r] = 0;
        stall_model = 0;
    endtask

    task automatic set_id(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                          input int rd, input bit wr, input int lat);
        id_valid_i   = v;
        id_rs_i      = REG_AW'(rs);
        id_rs_used_i = rsu;
        id_rt_i      = REG_AW'(rt);
        id_rt_used_i = rtu;
        id_rd_i      = REG_AW'(rd);
        id_wr_i      = wr;
        id_lat_i     = CW'(lat);
    endtask

    // Settle after the falling-edge drive and compare every output with the model.
    task automatic eval(input string tag);
        bit              st;
        logic [NREG-1:0] pv;
        #2;
        st = m_stall();
        for (int r = 0; r < NREG; r++) pv[r] = m_pending(r);
        check({tag, ".pc_write"}, 64'(pc_write_o), 64'(!st && !freeze_i));
        check({tag, ".if_id_write"}, 64'(if_id_write_o), 64'(!st && !freeze_i));
        check({tag, ".bubble"}, 64'(bubble_o), 64'((st || flush_i) && !freeze_i));
        check({tag, ".pending"}, 64'(pending_o), 64'(pv));
        check({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(stall_model));
    endtask

    task automatic tick();
        bit     st;
        bit     iss;
        longint l;
        st  = m_stall();
        iss = id_valid_i && !st && !flush_i && !freeze_i;
        @(posedge clk_i);
        if (!freeze_i) begin
            if (st && stall_model < SC_MAX) stall_model++;
            if (iss && id_wr_i && id_rd_i != 0 && id_lat_i != 0) begin
                l = (int'(id_lat_i) > MAX_LAT) ? MAX_LAT : int'(id_lat_i);
                if (t_now + 1 + l > ready[id_rd_i]) ready[id_rd_i] = t_now + 1 + l;
            end
            t_now++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i    = 1'b0;
        flush_i  = 1'b0;
        freeze_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check("reset.pending", 64'(pending_o), 64'(0));
        check("reset.stall_cnt", 64'(stall_cnt_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        eval("idle");
        check("idle.pc_write1", 64'(pc_write_o), 64'(1));
        check("idle.bubble0", 64'(bubble_o), 64'(0));
        tick();

        // Load-use with latency 1: exactly one stall cycle.
        set_id(1, 0, 0, 0, 0, 8, 1, 1);
        eval("ld8");
        tick();
        set_id(1, 8, 1, 0, 0, 0, 0, 0);
        eval("use8.stall");
        check("use8.pc_write0", 64'(pc_write_o), 64'(0));
        check("use8.bubble1", 64'(bubble_o), 64'(1));
        tick();
        eval("use8.release");
        check("use8.pc_write1", 64'(pc_write_o), 64'(1));
        check("use8.stall_cnt1", 64'(stall_cnt_o), 64'(1));
        tick();

        // Latency 3 on rt: three stalls, none when rt is not read.
        set_id(1, 0, 0, 0, 0, 9, 1, 3);
        eval("ld9");
        tick();
        set_id(1, 0, 0, 9, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            eval("use9.stall");
            check("use9.pc_write0", 64'(pc_write_o), 64'(0));
            tick();
        end
        eval("use9.release");
        check("use9.pc_write1", 64'(pc_write_o), 64'(1));
        tick();
        check("use9.stall_cnt4", 64'(stall_cnt_o), 64'(4));
        set_id(1, 0, 0, 0, 0, 9, 1, 3);
        eval("ld9b");
        tick();
        set_id(1, 0, 0, 9, 0, 0, 0, 0);
        eval("rt9_unused");
        check("rt9_unused.pc_write1", 64'(pc_write_o), 64'(1));
        tick();

        // Freeze holds cnt[9]=2; afterwards the reader stalls exactly twice.
        set_id(1, 0, 0, 9, 1, 0, 0, 0);
        freeze_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval("freeze");
            check("freeze.pending9", 64'(pending_o[9]), 64'(1));
            check("freeze.stall_cnt", 64'(stall_cnt_o), 64'(4));
            tick();
        end
        freeze_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            eval("post_freeze.stall");
            check("post_freeze.pc_write0", 64'(pc_write_o), 64'(0));
            tick();
        end
        eval("post_freeze.release");
        check("post_freeze.pc_write1", 64'(pc_write_o), 64'(1));
        tick();

        // Flush of a dependent instruction: bubble, PC advances, no stall counted.
        set_id(1, 0, 0, 0, 0, 4, 1, 2);
        eval("ld4");
        tick();
        set_id(1, 4, 1, 0, 0, 0, 0, 0);
        flush_i = 1'b1;
        eval("flush");
        check("flush.bubble1", 64'(bubble_o), 64'(1));
        check("flush.pc_write1", 64'(pc_write_o), 64'(1));
        check("flush.stall_cnt6", 64'(stall_cnt_o), 64'(6));
        tick();
        flush_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval("drain");
        tick();
        tick();

        // Register 0 is never pending; WAW keeps the longer latency.
        set_id(1, 0, 0, 0, 0, 0, 1, 3);
        eval("ld0");
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        eval("use0");
        check("use0.pending", 64'(pending_o), 64'(0));
        check("use0.pc_write1", 64'(pc_write_o), 64'(1));
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 3);
        eval("ld5a");
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        eval("ld5b");
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            eval("waw.stall");
            check("waw.pc_write0", 64'(pc_write_o), 64'(0));
            tick();
        end
        eval("waw.release");
        check("waw.pc_write1", 64'(pc_write_o), 64'(1));
        tick();

        // Reset mid-operation abandons cnt[4]=2.
        set_id(1, 0, 0, 0, 0, 4, 1, 2);
        eval("ld4r");
        tick();
        set_id(1, 4, 1, 0, 0, 0, 0, 0);
        #1 rst_i = 1'b0;
        #1;
        check("midreset.pending", 64'(pending_o), 64'(0));
        check("midreset.stall_cnt", 64'(stall_cnt_o), 64'(0));
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        eval("after_reset");
        check("after_reset.pc_write1", 64'(pc_write_o), 64'(1));
        tick();

        // Randomized traffic with occasional flush, freeze and reset.
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(9) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
                   $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(3));
            flush_i  = ($urandom_range(9) == 0);
            freeze_i = ($urandom_range(6) == 0);
            if ($urandom_range(99) == 0) begin
                rst_i = 1'b0;
                #1;
                check("rnd.reset_pending", 64'(pending_o), 64'(0));
                model_reset();
                @(posedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b1;
            end
            eval("rnd");
            tick();
        end
        flush_i  = 1'b0;
        freeze_i = 1'b0;

        // Saturation of the stall counter.
        rst_i = 1'b0;
        #1;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_id(1, 0, 0, 0, 0, 3, 1, 3);
            eval("sat.ld");
            tick();
            set_id(1, 3, 1, 0, 0, 0, 0, 0);
            for (int j = 0; j < 4; j++) begin
                eval("sat.use");
                tick();
            end
        end
        eval("sat.end");
        check("sat.stall_cnt_max", 64'(stall_cnt_o), 64'(SC_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
